// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the 16-bit multicycle datapath (optional CTRL_ILLEGAL_TRAP_EN)
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSource,
    output logic       mem_err,
    output logic       trap
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        R_WB     = 4'd8,
        EXEC_I   = 4'd9,
        I_WB     = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        TRAP     = 4'd13
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ORI   = 4'd2;
    localparam logic [3:0] OP_LW    = 4'd3;
    localparam logic [3:0] OP_SW    = 4'd4;
    localparam logic [3:0] OP_BEQ   = 4'd5;
    localparam logic [3:0] OP_J     = 4'd6;

    localparam logic [1:0] SRCB_REGB  = 2'd0;
    localparam logic [1:0] SRCB_ONE   = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_FUNC = 2'd2;
    localparam logic [1:0] ALU_OR   = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Last count value before an unanswered access is abandoned
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] tmo_cnt;
    logic       mem_state;
    logic       mem_wait;
    logic       tmo_hit;
    logic       ori_sel;
    logic       store_sel;

    // Memory-access states wait on mem_ready; a stall at the last count aborts
    always_comb begin
        mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
        mem_wait  = mem_state && !mem_ready;
        tmo_hit   = mem_wait && (tmo_cnt == TMO_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Opcode is only looked at in DECODE; remember what later states need from it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ori_sel   <= 1'b0;
            store_sel <= 1'b0;
        end else if (state == DECODE) begin
            ori_sel   <= (opcode == OP_ORI);
            store_sel <= (opcode == OP_SW);
        end
    end

    // Consecutive wait-cycle counter; any state change or abort restarts it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt <= 8'd0;
        end else if (mem_wait && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= 8'd0;
        end
    end

    // Timeout is reported one cycle after the abort decision
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= tmo_hit;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    state_next = DECODE;
                end else if (tmo_hit) begin
                    state_next = FETCH;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:       state_next = EXEC_R;
                    OP_ADDI,
                    OP_ORI:         state_next = EXEC_I;
                    OP_LW,
                    OP_SW:          state_next = MEM_ADDR;
                    OP_BEQ:         state_next = BRANCH;
                    OP_J:           state_next = JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:        state_next = TRAP;
`else
                    default:        state_next = FETCH;
`endif
                endcase
            end
            MEM_ADDR: state_next = store_sel ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (mem_ready) begin
                    state_next = MEM_WB;
                end else if (tmo_hit) begin
                    state_next = FETCH;
                end
            end
            MEM_WB: state_next = FETCH;
            MEM_WR: begin
                if (mem_ready || tmo_hit) begin
                    state_next = FETCH;
                end
            end
            EXEC_R: state_next = R_WB;
            R_WB:   state_next = FETCH;
            EXEC_I: state_next = I_WB;
            I_WB:   state_next = FETCH;
            BRANCH: state_next = FETCH;
            JUMP:   state_next = FETCH;
            TRAP:   state_next = TRAP;
            default: state_next = IDLE;
        endcase
    end

    // Moore control decode; FETCH qualifies its register writes with mem_ready
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REGB;
        ALUop       = ALU_ADD;
        PCSource    = PCSRC_ALU;
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap        = 1'b0;
`endif
        case (state)
            FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_ONE;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
            end
            DECODE: begin
                ALUSrcB  = SRCB_IMMSH;
            end
            MEM_ADDR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
            end
            MEM_RD: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA  = 1'b1;
                ALUop    = ALU_FUNC;
            end
            R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            EXEC_I: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                ALUop    = ori_sel ? ALU_OR : ALU_ADD;
            end
            I_WB: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                trap     = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

`ifndef CTRL_ILLEGAL_TRAP_EN
    assign trap = 1'b0;
`endif

endmodule
